// File: rtl/ibex_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Holds the clear-sequencer state encoding and the x0/RV32E discard rule.
package ibex_pkg;

    typedef enum logic [0:0] {
        RF_WB_IDLE  = 1'b0,
        RF_WB_CLEAR = 1'b1
    } rf_wb_state_e;

    localparam int unsigned RF_WB_DW = 32;

    typedef struct packed {
        logic                we;
        logic [4:0]          waddr;
        logic [RF_WB_DW-1:0] wdata;
    } rf_wr_req_t;

    // x0 is hardwired; under RV32E the upper 16 registers do not exist.
    function automatic logic rf_wb_discard(input logic [4:0] waddr, input logic rv32e);
        return (waddr == 5'd0) || (rv32e && waddr[4]);
    endfunction

endpackage

// File: rtl/ibex_rf_wb_rr_arb.sv
// Two-requester round-robin arbiter; index 0 is the LSU, index 1 the ALU.
// Priority moves to the other requester only on an accepted grant.
module ibex_rf_wb_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic       r_prio;
    logic [1:0] w_gnt;

    // Grant: contention resolved by the pointer, a lone request always wins.
    always_comb begin
        w_gnt = 2'b00;
        case (req_i)
            2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            default: w_gnt = 2'b00;
        endcase
    end

    // Pointer register: favour whoever was not granted last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio <= 1'b0;
        end else if (accept_i && (w_gnt != 2'b00)) begin
            r_prio <= w_gnt[0];
        end else begin
            r_prio <= r_prio;
        end
    end

    assign gnt_o = w_gnt;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-port arbiter between ALU and LSU writeback paths.
// Define IBEX_RF_WB_CLEAR_EN to include the zero-all-registers clear sequencer.
module ibex_rf_wb_arbiter
    import ibex_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [4:0]           alu_waddr_i,
    input  logic [DataWidth-1:0] alu_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    input  logic                 clear_req_i,
    output logic                 clear_busy_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o
);

    localparam logic [4:0] LAST_ADDR = RV32E ? 5'd15 : 5'd31;

    logic                 w_arb_en;
    logic [1:0]           w_req;
    logic [1:0]           w_gnt;
    logic                 w_hs;
    logic [4:0]           w_sel_addr;
    logic [DataWidth-1:0] w_sel_data;
    logic                 w_clr_active;
    logic [4:0]           w_clr_addr;

    logic                 r_we;
    logic [4:0]           r_waddr;
    logic [DataWidth-1:0] r_wdata;

`ifdef IBEX_RF_WB_CLEAR_EN
    rf_wb_state_e r_state;
    rf_wb_state_e w_state_nxt;
    logic [4:0]   r_cnt;
    logic [4:0]   w_cnt_nxt;

    // State and clear-address counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RF_WB_IDLE;
            r_cnt   <= 5'd1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: clear requests are only honoured while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_WB_IDLE: begin
                if (clear_req_i) begin
                    w_state_nxt = RF_WB_CLEAR;
                end else begin
                    w_state_nxt = RF_WB_IDLE;
                end
            end
            RF_WB_CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = RF_WB_IDLE;
                    w_cnt_nxt   = 5'd1;
                end else begin
                    w_cnt_nxt   = r_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = RF_WB_IDLE;
                w_cnt_nxt   = 5'd1;
            end
        endcase
    end

    assign w_arb_en     = (r_state == RF_WB_IDLE);
    assign w_clr_active = (r_state == RF_WB_CLEAR);
    assign w_clr_addr   = r_cnt;
    assign clear_busy_o = w_clr_active;
`else
    logic w_unused_clear;

    assign w_unused_clear = clear_req_i;
    assign w_arb_en       = 1'b1;
    assign w_clr_active   = 1'b0;
    assign w_clr_addr     = 5'd0;
    assign clear_busy_o   = 1'b0;
`endif

    assign w_req = {alu_valid_i, lsu_valid_i} & {2{w_arb_en}};

    ibex_rf_wb_rr_arb u_rr_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (w_req),
        .accept_i (w_arb_en),
        .gnt_o    (w_gnt)
    );

    assign lsu_ready_o = w_gnt[0];
    assign alu_ready_o = w_gnt[1];
    assign w_hs        = (w_gnt != 2'b00);

    // Route the granted requester onto the write path.
    always_comb begin
        w_sel_addr = lsu_waddr_i;
        w_sel_data = lsu_wdata_i;
        if (w_gnt[1]) begin
            w_sel_addr = alu_waddr_i;
            w_sel_data = alu_wdata_i;
        end else begin
            w_sel_addr = lsu_waddr_i;
            w_sel_data = lsu_wdata_i;
        end
    end

    // Registered write port; address and data hold when no write issues.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= {DataWidth{1'b0}};
        end else if (w_clr_active) begin
            r_we    <= 1'b1;
            r_waddr <= w_clr_addr;
            r_wdata <= {DataWidth{1'b0}};
        end else if (w_hs && !rf_wb_discard(w_sel_addr, RV32E)) begin
            r_we    <= 1'b1;
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rf_we_o    = r_we;
    assign rf_waddr_o = r_waddr;
    assign rf_wdata_o = r_wdata;

endmodule
